// File: rtl/sm_als_responder_pkg.sv
// Shared ALS link frame constants and responder state type.
// Frame constants live here instead of an include file so the SoC-side master can import the same values.
package sm_als_responder_pkg;

    localparam int unsigned SM_ALS_FRAME_BITS = 16;
    localparam int unsigned SM_ALS_LEAD_ZEROS = 3;
    localparam int unsigned SM_ALS_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } als_state_t;

endpackage

// File: rtl/sm_sync_edge.sv
// N-stage async-reset synchronizer with one history flop and rise/fall pulses in the clk domain.
module sm_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    // Reset to the idle level so releasing reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            hist  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~hist;
    assign fall = ~chain[STAGES-1] & hist;

endmodule

// File: rtl/sm_als_responder.sv
// SPI responder emulating an 8-bit ambient light sensor ADC: latches a sample on CS fall
// and shifts it out MSB-first on SCK falls, framed by leading and trailing zeros.
module sm_als_responder
    import sm_als_responder_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = SM_ALS_FRAME_BITS,
    parameter int unsigned LEAD_ZEROS  = SM_ALS_LEAD_ZEROS,
    parameter int unsigned DATA_WIDTH  = SM_ALS_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sampleData,
    input  logic                  alsCS,
    input  logic                  alsSCK,
    output logic                  alsSDO,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  frameAbort,
    output logic [15:0]           frameCnt
);

    localparam int unsigned TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
    localparam int unsigned CNT_W       = $clog2(FRAME_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    als_state_t            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] load_word;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  cs_rise, cs_fall;
    logic                  sck_fall, sck_rise_unused;

    sm_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (alsCS),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sm_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (alsSCK),
        .rise  (sck_rise_unused),
        .fall  (sck_fall)
    );

    // Leading zeros fall out of the zero-extension; trailing zeros come from the shift.
    assign load_word = FRAME_BITS'(sampleData) << TRAIL_ZEROS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            alsSDO     <= 1'b0;
            busy       <= 1'b0;
            frameDone  <= 1'b0;
            frameAbort <= 1'b0;
            frameCnt   <= '0;
        end else begin
            frameDone  <= 1'b0;
            frameAbort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    alsSDO <= 1'b0;
                    busy   <= 1'b0;
                    if (cs_fall) begin
                        shreg   <= load_word;
                        bit_cnt <= '0;
                        alsSDO  <= load_word[FRAME_BITS-1];
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // CS release takes priority over a coincident SCK fall.
                    if (cs_rise) begin
                        frameAbort <= 1'b1;
                        alsSDO     <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (sck_fall) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            alsSDO <= 1'b0;
                            state  <= ST_DONE;
                        end else begin
                            alsSDO <= shreg[FRAME_BITS-2];
                        end
                    end
                end
                ST_DONE: begin
                    alsSDO <= 1'b0;
                    if (cs_rise) begin
                        frameDone <= 1'b1;
                        frameCnt  <= frameCnt + 16'd1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    alsSDO <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
